// File: rtl/change_gen_pkg.sv
// Shared definitions for the change generator: default widths, pattern
// mode codes, LFSR taps and FSM state encoding.
package change_gen_pkg;

  // Default widths of the data word and of the word/transfer counters
  localparam int DATA_W_DEF = 12;
  localparam int CNT_W_DEF  = 5;

  // Pattern selectors; code 3 is not listed and falls back to increment
  localparam logic [1:0] MODE_INC  = 2'd0;
  localparam logic [1:0] MODE_LFSR = 2'd1;
  localparam logic [1:0] MODE_WALK = 2'd2;

  // Right-shifting Galois taps for x^12 + x^11 + x^10 + x^4 + 1
  localparam logic [11:0] LFSR_TAPS = 12'hE08;

  // Burst controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/change_gen_next.sv
// Combinational next-word function. Every mode is built so that the result
// never equals the current word, which keeps consecutive emitted words
// distinct and lets a change counter at the sink count words exactly.
module change_gen_next
  import change_gen_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] cur,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] nxt
);

  logic [DATA_W-1:0] inc_word;
  logic [DATA_W-1:0] rot_word;
  logic [DATA_W-1:0] lfsr_word;
  logic              cur_zero;

  // Candidate words for every mode, then the mode select with the escapes
  // out of the states where a pattern would otherwise lock up or repeat:
  // zero is a fixed point of both the LFSR and the rotate, and all-ones is
  // a fixed point of the rotate, so those step to a different word instead.
  always_comb begin
    inc_word  = cur + DATA_W'(1);
    rot_word  = {cur[DATA_W-2:0], cur[DATA_W-1]};
    lfsr_word = (cur >> 1) ^ (cur[0] ? DATA_W'(LFSR_TAPS) : '0);
    cur_zero  = (cur == '0);
    nxt       = inc_word;

    case (mode)
      MODE_LFSR: begin
        if (cur_zero) nxt = DATA_W'(1);
        else          nxt = lfsr_word;
      end
      MODE_WALK: begin
        if (cur_zero)              nxt = DATA_W'(1);
        else if (rot_word == cur)  nxt = inc_word;
        else                       nxt = rot_word;
      end
      default: nxt = inc_word;
    endcase
  end

endmodule

// File: rtl/change_generator.sv
// Burst word generator: on start, emits num_words words on a valid/ready
// interface, each different from the one before, then pulses done.
module change_generator
  import change_gen_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_words,
  input  logic [DATA_W-1:0] seed,
  input  logic [1:0]        mode,
  input  logic              ready,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sent
);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  count_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  sent_q;
  logic [DATA_W-1:0] next_word;
  logic [DATA_W-1:0] first_word;
  logic              transfer;
  logic              last_transfer;
  logic              capture;
  logic              load_first;
  logic              advance;

  change_gen_next #(
    .DATA_W (DATA_W)
  ) u_next (
    .cur  (data_q),
    .mode (mode_q),
    .nxt  (next_word)
  );

  // The first word must also differ from whatever is already on data_out,
  // so a seed equal to the current word is bumped by one.
  always_comb begin
    first_word    = (seed == data_q) ? seed + DATA_W'(1) : seed;
    transfer      = (state == ST_SEND) && ready;
    last_transfer = transfer && ((sent_q + CNT_W'(1)) == count_q);
  end

  // Next-state and output decode; start only matters in IDLE
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    load_first = 1'b0;
    advance    = 1'b0;
    valid      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          capture = 1'b1;
          if (num_words == '0) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_SEND;
            load_first = 1'b1;
          end
        end
      end
      ST_SEND: begin
        valid = 1'b1;
        busy  = 1'b1;
        if (last_transfer)  state_next = ST_DONE;
        else if (transfer)  advance    = 1'b1;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; reset aborts any burst without a done pulse
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Burst parameters latched with an accepted start
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      mode_q  <= MODE_INC;
    end else if (capture) begin
      count_q <= num_words;
      mode_q  <= mode;
    end
  end

  // Output word only moves on the first-word load or on a non-final transfer
  always_ff @(posedge clk) begin
    if (!reset)          data_q <= '0;
    else if (load_first) data_q <= first_word;
    else if (advance)    data_q <= next_word;
  end

  // Transfer counter, cleared by a new start and held after the burst
  always_ff @(posedge clk) begin
    if (!reset)        sent_q <= '0;
    else if (capture)  sent_q <= '0;
    else if (transfer) sent_q <= sent_q + CNT_W'(1);
  end

  assign data_out = data_q;
  assign sent     = sent_q;

endmodule

// File: tb/tb_change_generator.sv
// Directed bench for change_generator: bursts are scored against a queue of
// words produced by a reference pattern model when each start is driven.
module tb_change_generator;

  localparam int DATA_W = 12;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  num_words = '0;
  logic [DATA_W-1:0] seed = '0;
  logic [1:0]        mode = 2'd0;
  logic              ready = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  sent;

  int                nChecks = 0;
  int                nFail = 0;
  logic [DATA_W-1:0] sbQ[$];
  logic [DATA_W-1:0] modelData = '0;
  logic [DATA_W-1:0] preData = '0;
  int                expCount = 0;

  change_generator #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_words (num_words),
    .seed      (seed),
    .mode      (mode),
    .ready     (ready),
    .data_out  (data_out),
    .valid     (valid),
    .busy      (busy),
    .done      (done),
    .sent      (sent)
  );

  always #5 clk = ~clk;

  // Reference pattern generator
  function automatic logic [11:0] modelNext(input logic [11:0] x, input logic [1:0] m);
    logic [11:0] r;
    if (m == 2'd1) begin
      if (x == 12'h000) r = 12'h001;
      else begin
        r = {1'b0, x[11:1]};
        if (x[0]) r = r ^ 12'hE08;
      end
    end else if (m == 2'd2) begin
      if (x == 12'h000)      r = 12'h001;
      else if (x == 12'hFFF) r = 12'h000;
      else                   r = {x[10:0], x[11]};
    end else begin
      r = x + 12'h001;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_data"},  32'(data_out), 32'h0);
    checkOutput({tag, "_valid"}, 32'(valid), 32'h0);
    checkOutput({tag, "_busy"},  32'(busy), 32'h0);
    checkOutput({tag, "_done"},  32'(done), 32'h0);
    checkOutput({tag, "_sent"},  32'(sent), 32'h0);
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 with reset released
  task automatic doReset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkIdleZero("reset");
    reset = 1'b1;
    sbQ.delete();
    modelData = '0;
  endtask

  // Drives one start and pushes the words the burst must produce
  task automatic applyStimulus(input int n, input logic [11:0] s, input logic [1:0] m);
    logic [11:0] w;
    start     = 1'b1;
    num_words = n[CNT_W-1:0];
    seed      = s;
    mode      = m;
    preData   = data_out;
    expCount  = n;
    if (n != 0) begin
      w = (s == modelData) ? s + 12'h001 : s;
      for (int i = 0; i < n; i++) begin
        sbQ.push_back(w);
        modelData = w;
        w = modelNext(w, m);
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Runs the burst to completion, popping the scoreboard on each transfer
  task automatic drainBurst(input string tag, input logic [31:0] readyPat,
                            input logic [31:0] startPat, input int budget);
    bit          seenDone;
    int          changes;
    logic [11:0] prev;
    seenDone = 1'b0;
    changes  = 0;
    prev     = preData;
    for (int c = 0; c < budget && !seenDone; c++) begin
      ready = (c < 32) ? readyPat[c] : 1'b1;
      start = (c < 32) ? startPat[c] : 1'b0;
      if (start) begin
        num_words = 5'd7;
        seed      = 12'h3AB;
        mode      = 2'd1;
      end
      @(negedge clk);
      if (data_out !== prev) changes++;
      prev = data_out;
      if (sbQ.size() > 0) begin
        checkOutput({tag, "_valid"}, 32'(valid), 32'h1);
        checkOutput({tag, "_busy"},  32'(busy), 32'h1);
        checkOutput({tag, "_word"},  32'(data_out), 32'(sbQ[0]));
        checkOutput({tag, "_early_done"}, 32'(done), 32'h0);
        if (ready) void'(sbQ.pop_front());
      end else begin
        checkOutput({tag, "_end_valid"}, 32'(valid), 32'h0);
        checkOutput({tag, "_end_busy"},  32'(busy), 32'h0);
        checkOutput({tag, "_done"},      32'(done), 32'h1);
        checkOutput({tag, "_end_data"},  32'(data_out), 32'(modelData));
        checkOutput({tag, "_end_sent"},  32'(sent), 32'(expCount));
        seenDone = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    checkOutput({tag, "_drained"}, 32'(sbQ.size()), 32'h0);
    @(negedge clk);
    if (data_out !== prev) changes++;
    checkOutput({tag, "_idle_done"}, 32'(done), 32'h0);
    checkOutput({tag, "_idle_valid"}, 32'(valid), 32'h0);
    checkOutput({tag, "_held_sent"}, 32'(sent), 32'(expCount));
    checkOutput({tag, "_held_data"}, 32'(data_out), 32'(modelData));
    checkOutput({tag, "_changes"}, 32'(changes), 32'(expCount));
    @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] change_generator bench starting");
    @(posedge clk);
    #1;
    doReset();

    // Increment burst, sink always ready
    applyStimulus(4, 12'h005, 2'd0);
    drainBurst("inc4", 32'hFFFF_FFFF, 32'h0, 20);

    // Increment across the wrap with stalls (ready 1,0,0,1,1)
    applyStimulus(3, 12'hFFE, 2'd0);
    drainBurst("incwrap", 32'hFFFF_FFF9, 32'h0, 20);

    // LFSR from a zero seed right after reset escapes to 1
    doReset();
    applyStimulus(31, 12'h000, 2'd1);
    drainBurst("lfsr31", 32'hFFFF_FFFF, 32'h0, 40);

    // Empty burst
    applyStimulus(0, 12'h123, 2'd0);
    drainBurst("empty", 32'hFFFF_FFFF, 32'h0, 5);

    // Walking one
    applyStimulus(2, 12'h800, 2'd2);
    drainBurst("walk", 32'hFFFF_FFFF, 32'h0, 10);

    // Reset in the middle of a burst aborts it with no done
    applyStimulus(5, 12'h100, 2'd0);
    ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkIdleZero("abort");
    reset = 1'b1;
    sbQ.delete();
    modelData = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abort_no_done", 32'(done), 32'h0);
      checkOutput("abort_no_valid", 32'(valid), 32'h0);
    end
    @(posedge clk);
    #1;

    // start pulsed in SEND and in DONE is ignored; mode 3 acts as increment
    applyStimulus(3, 12'h020, 2'd3);
    drainBurst("ignstart", 32'hFFFF_FFFF, 32'h0000_000A, 10);

    // New burst whose seed equals the last word starts at seed+1
    applyStimulus(2, 12'h022, 2'd0);
    drainBurst("seedbump", 32'hFFFF_FFFF, 32'h0, 10);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
